// File: rtl/hs_xfer.sv
// hs_xfer: hiscore save/restore engine, pauses the machine and copies up to two video-RAM regions to/from an 8-bit buffer RAM
module hs_xfer #(
  parameter logic [15:0] REG0_BASE = 16'hE000,
  parameter logic [15:0] REG0_LEN  = 16'd0,
  parameter logic [15:0] REG1_BASE = 16'hD000,
  parameter logic [15:0] REG1_LEN  = 16'd0,
  parameter int          RD_LAT    = 2,
  parameter int          SETTLE    = 4
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        start,
  input  logic        dir,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        HS_PAUSE_N,
  output logic [15:0] HSAD,
  input  logic [7:0]  HSDO,
  output logic [7:0]  HSDI,
  output logic        HSWE,
  output logic [11:0] buf_ad,
  output logic [7:0]  buf_dw,
  output logic        buf_wr,
  input  logic [7:0]  buf_dr
);
  typedef enum logic [2:0] {IDLE, PAUSE, ADDR, WAIT, XFER, RELEASE} state_t;
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);
  localparam logic [7:0] WAIT_M1   = 8'(RD_LAT - 2);
  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [15:0] idx, idx_n;
  logic        sel, sel_n;
  logic [11:0] off, off_n;
  logic        dir_q, dir_n;
  logic [15:0] len_cur;
  assign len_cur = sel ? REG1_LEN : REG0_LEN;
  // next-state and walk bookkeeping: region select, region index, buffer offset, cycle counter
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 8'd1;
    idx_n   = idx;
    sel_n   = sel;
    off_n   = off;
    dir_n   = dir_q;
    case (state)
      IDLE: if (start && !abort) begin
        state_n = PAUSE;
        dir_n   = dir;
        off_n   = '0;
        sel_n   = (REG0_LEN == '0);
        idx_n   = '0;
        cnt_n   = '0;
      end
      PAUSE: if (cnt == SETTLE_M1)
        state_n = (REG0_LEN == '0 && REG1_LEN == '0) ? RELEASE : ADDR;
      ADDR: begin
        state_n = (RD_LAT == 1) ? XFER : WAIT;
        cnt_n   = '0;
      end
      WAIT: if (cnt == WAIT_M1) state_n = XFER;
      XFER: begin
        off_n   = off + 12'd1;
        idx_n   = idx + 16'd1;
        state_n = ADDR;
        if (idx_n == len_cur) begin
          if (!sel && REG1_LEN != '0) begin
            sel_n = 1'b1;
            idx_n = '0;
          end else state_n = RELEASE;
        end
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort && state != IDLE) state_n = IDLE;
  end
  // state register plus outputs registered from the state being entered
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      sel        <= 1'b0;
      off        <= '0;
      dir_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      HS_PAUSE_N <= 1'b1;
      HSAD       <= '0;
      HSDI       <= '0;
      HSWE       <= 1'b0;
      buf_ad     <= '0;
      buf_dw     <= '0;
      buf_wr     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      sel        <= sel_n;
      off        <= off_n;
      dir_q      <= dir_n;
      busy       <= state_n != IDLE;
      done       <= state_n == RELEASE;
      HS_PAUSE_N <= state_n == IDLE || state_n == RELEASE;
      HSWE       <= state_n == XFER && dir_n;
      buf_wr     <= state_n == XFER && !dir_n;
      if (state_n == ADDR) begin
        HSAD   <= (sel_n ? REG1_BASE : REG0_BASE) + idx_n;
        buf_ad <= off_n;
      end
      if (state_n == XFER && !dir_n) buf_dw <= HSDO;
      if (state_n == XFER && dir_n) HSDI <= buf_dr;
    end
  end
endmodule

// File: tb/tb_hs_xfer.sv
// tb_hs_xfer: directed/randomized save, restore, abort and reset checks against memory and timing models
module tb_hs_xfer;
  localparam logic [15:0] R0B = 16'hE000, R0L = 16'd2, R1B = 16'hD000, R1L = 16'd2;
  localparam int LAT = 2, SET = 4, NB = 4;
  localparam int T_DONE = 1 + SET + NB * (LAT + 1);
  logic clk = 1'b0;
  logic RESET_N, start, dir, abort;
  logic busy, done, HS_PAUSE_N, HSWE, buf_wr;
  logic [15:0] HSAD;
  logic [7:0] HSDO, HSDI, buf_dw, buf_dr;
  logic [11:0] buf_ad;
  logic start_e, e_busy, e_done, e_pn, e_we, e_bw;
  logic [15:0] e_ad;
  logic [7:0] e_di, e_dw;
  logic [11:0] e_bad;
  logic [7:0] e_rd = 8'h00;
  logic abort_e = 1'b0;
  logic [7:0] vram [0:65535];
  logic [7:0] bufm [0:4095];
  logic [15:0] map_a [$];
  logic [7:0] exp_m [NB];
  int n_tests = 0, n_fail = 0;
  hs_xfer #(.REG0_BASE(R0B), .REG0_LEN(R0L), .REG1_BASE(R1B), .REG1_LEN(R1L), .RD_LAT(LAT), .SETTLE(SET)) u_dut (
    .clk(clk), .RESET_N(RESET_N), .start(start), .dir(dir), .abort(abort), .busy(busy), .done(done),
    .HS_PAUSE_N(HS_PAUSE_N), .HSAD(HSAD), .HSDO(HSDO), .HSDI(HSDI), .HSWE(HSWE),
    .buf_ad(buf_ad), .buf_dw(buf_dw), .buf_wr(buf_wr), .buf_dr(buf_dr));
  hs_xfer #(.REG0_LEN(16'd0), .REG1_LEN(16'd0), .RD_LAT(LAT), .SETTLE(SET)) u_empty (
    .clk(clk), .RESET_N(RESET_N), .start(start_e), .dir(1'b1), .abort(abort_e), .busy(e_busy), .done(e_done),
    .HS_PAUSE_N(e_pn), .HSAD(e_ad), .HSDO(e_rd), .HSDI(e_di), .HSWE(e_we),
    .buf_ad(e_bad), .buf_dw(e_dw), .buf_wr(e_bw), .buf_dr(e_rd));
  always #5 clk = ~clk;
  // registered one-cycle-latency read ports of the video RAM and buffer models
  always @(posedge clk) begin
    HSDO   <= vram[HSAD];
    buf_dr <= bufm[buf_ad];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic d, input int abort_at, input int poke_at,
                     output int done_cyc, output int plo, output int nwe, output int nbw,
                     output logic p1, output logic b1, output logic pa, output logic ba);
    dir = d; start = 1'b1; done_cyc = 0; plo = 0; nwe = 0; nbw = 0;
    p1 = 1'bx; b1 = 1'bx; pa = 1'bx; ba = 1'bx;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = (k == poke_at);
      if (k == 1) begin p1 = HS_PAUSE_N; b1 = busy; end
      if (k == abort_at + 1) begin pa = HS_PAUSE_N; ba = busy; end
      if (!HS_PAUSE_N) plo++;
      if (HSWE) begin nwe++; vram[HSAD] = HSDI; end
      if (buf_wr) begin nbw++; bufm[buf_ad] = buf_dw; end
      if (done) begin done_cyc = k; break; end
      if (abort_at != 0 && k == abort_at + 6) break;
      abort = (k == abort_at);
    end
    start = 1'b0; abort = 1'b0;
  endtask
  int dc, plo, nwe, nbw, bad;
  logic p1, b1, pa, ba, d;
  initial begin
    RESET_N = 1'b0; start = 1'b0; dir = 1'b0; abort = 1'b0; start_e = 1'b0;
    for (int i = 0; i < int'(R0L); i++) map_a.push_back(R0B + 16'(i));
    for (int i = 0; i < int'(R1L); i++) map_a.push_back(R1B + 16'(i));
    repeat (2) @(negedge clk);
    chk("rst_pause_n", HS_PAUSE_N, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_hsad", HSAD, 0); chk("rst_hswe", HSWE, 0); chk("rst_bufwr", buf_wr, 0);
    RESET_N = 1'b1;
    @(negedge clk);
    // save with HSDO = addr[7:0], plus a start pulse while busy
    foreach (map_a[j]) begin vram[map_a[j]] = map_a[j][7:0]; exp_m[j] = map_a[j][7:0]; bufm[j] = 8'hFF; end
    run(1'b0, 0, 5, dc, plo, nwe, nbw, p1, b1, pa, ba);
    chk("save_pause_c1", p1, 0); chk("save_busy_c1", b1, 1);
    chk("save_done_cyc", dc, T_DONE); chk("save_pause_len", plo, T_DONE - 1);
    chk("save_nbufwr", nbw, NB); chk("save_nhswe", nwe, 0);
    for (int j = 0; j < NB; j++) chk($sformatf("save_buf%0d", j), bufm[j], exp_m[j]);
    @(negedge clk);
    chk("after_done_pulse", done, 0); chk("after_busy", busy, 0); chk("after_pause_n", HS_PAUSE_N, 1);
    // restore of AA,BB,CC,DD
    exp_m = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int j = 0; j < NB; j++) bufm[j] = exp_m[j];
    run(1'b1, 0, 0, dc, plo, nwe, nbw, p1, b1, pa, ba);
    chk("rest_done_cyc", dc, T_DONE); chk("rest_nhswe", nwe, NB); chk("rest_nbufwr", nbw, 0);
    for (int j = 0; j < NB; j++) chk($sformatf("rest_vram_%0h", map_a[j]), vram[map_a[j]], exp_m[j]);
    @(negedge clk);
    // randomized transfers in both directions
    repeat (4) begin
      d = 1'($urandom);
      for (int j = 0; j < NB; j++) begin
        vram[map_a[j]] = 8'($urandom); bufm[j] = 8'($urandom);
        exp_m[j] = d ? bufm[j] : vram[map_a[j]];
      end
      run(d, 0, 0, dc, plo, nwe, nbw, p1, b1, pa, ba);
      chk("rnd_done_cyc", dc, T_DONE);
      chk("rnd_strobes", d ? nwe : nbw, NB);
      for (int j = 0; j < NB; j++) chk("rnd_data", d ? vram[map_a[j]] : bufm[j], exp_m[j]);
      @(negedge clk);
    end
    // abort while byte 2 of a restore is waiting for its write
    for (int j = 0; j < NB; j++) begin
      vram[map_a[j]] = 8'($urandom); bufm[j] = 8'($urandom);
      exp_m[j] = (j < 2) ? bufm[j] : vram[map_a[j]];
    end
    run(1'b1, 1 + SET + 2 * (LAT + 1) + 1, 0, dc, plo, nwe, nbw, p1, b1, pa, ba);
    chk("abort_no_done", dc, 0); chk("abort_nhswe", nwe, 2);
    chk("abort_pause_n", pa, 1); chk("abort_busy", ba, 0);
    for (int j = 0; j < NB; j++) chk($sformatf("abort_vram_%0h", map_a[j]), vram[map_a[j]], exp_m[j]);
    // start together with abort in IDLE is dropped
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; bad = 0;
    repeat (SET + 4) begin
      if (busy || done || !HS_PAUSE_N) bad++;
      @(negedge clk);
    end
    chk("start_abort_idle", bad, 0);
    // asynchronous reset mid-save, then a clean save from offset 0
    dir = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_pause_n", HS_PAUSE_N, 0);
    RESET_N = 1'b0;
    #1;
    chk("arst_pause_n", HS_PAUSE_N, 1); chk("arst_busy", busy, 0); chk("arst_hsad", HSAD, 0);
    @(negedge clk);
    RESET_N = 1'b1;
    @(negedge clk);
    for (int j = 0; j < NB; j++) begin vram[map_a[j]] = 8'($urandom); bufm[j] = 8'hFF; exp_m[j] = vram[map_a[j]]; end
    run(1'b0, 0, 0, dc, plo, nwe, nbw, p1, b1, pa, ba);
    chk("post_rst_done_cyc", dc, T_DONE);
    for (int j = 0; j < NB; j++) chk($sformatf("post_rst_buf%0d", j), bufm[j], exp_m[j]);
    // both regions empty: pause then done, no strobes
    start_e = 1'b1; dc = 0; plo = 0; bad = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start_e = 1'b0;
      if (!e_pn) plo++;
      if (e_we || e_bw) bad++;
      if (e_done) begin dc = k; break; end
    end
    chk("empty_done_cyc", dc, 1 + SET); chk("empty_pause_len", plo, SET); chk("empty_strobes", bad, 0);
    chk("empty_addr", {e_ad, e_bad}, 0); chk("empty_data", {e_di, e_dw}, 0);
    @(negedge clk);
    chk("empty_idle", e_busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
